elevator_call_latch: RTL and testbench



---
 rtl/elevator_call_latch.sv | 150 +++++++++++++++
 tb/tb_elevator_call_latch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_latch.sv
// Seven-channel push-button front end: 2-flop synchroniser, optional debounce
// (ELEVATOR_CALL_DEBOUNCE_EN), rising-edge press detect and a clear-dominant request latch.
// state   | meaning
// IDLE    | no call latched, lamp off
// PENDING | call latched, lamp on until the matching clear
module elevator_call_latch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       raw_floor_1_up,
    input  logic       raw_floor_2_up,
    input  logic       raw_floor_2_down,
    input  logic       raw_floor_3_down,
    input  logic       raw_car_floor_1,
    input  logic       raw_car_floor_2,
    input  logic       raw_car_floor_3,
    input  logic       floor_1_up_button_clear,
    input  logic       floor_2_up_button_clear,
    input  logic       floor_2_down_button_clear,
    input  logic       floor_3_down_button_clear,
    input  logic       elevator_floor_1_button_clear,
    input  logic       elevator_floor_2_button_clear,
    input  logic       elevator_floor_3_button_clear,
    output logic       floor_1_up_button,
    output logic       floor_2_up_button,
    output logic       floor_2_down_button,
    output logic       floor_3_down_button,
    output logic       elevator_floor_1_button,
    output logic       elevator_floor_2_button,
    output logic       elevator_floor_3_button,
    output logic [2:0] pending_count,
    output logic       any_pending
);

    localparam int N = 7;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [N-1:0] raw;
    logic [N-1:0] clr;
    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] lvl;
    logic [N-1:0] lvl_d;
    logic [N-1:0] press;
    logic [N-1:0] req;
    state_t       state_q [N];
    state_t       state_d [N];

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be in 1..15");
    end

    assign raw = {raw_car_floor_3, raw_car_floor_2, raw_car_floor_1, raw_floor_3_down,
                  raw_floor_2_down, raw_floor_2_up, raw_floor_1_up};
    assign clr = {elevator_floor_3_button_clear, elevator_floor_2_button_clear,
                  elevator_floor_1_button_clear, floor_3_down_button_clear,
                  floor_2_down_button_clear, floor_2_up_button_clear, floor_1_up_button_clear};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef ELEVATOR_CALL_DEBOUNCE_EN
    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0] stable;
    logic [3:0]   cnt [N];

    // The synchronised level must disagree with the accepted value for
    // DEBOUNCE_CYCLES consecutive cycles before it is taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stable <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    assign lvl = stable;
`else
    assign lvl = s2;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lvl_d <= '0;
        else       lvl_d <= lvl;
    end

    assign press = lvl & ~lvl_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) state_q[i] <= IDLE;
        end else begin
            for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
        end
    end

    // Clear wins over a same-cycle press; that press is dropped, not deferred.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (press[i] && !clr[i]) state_d[i] = PENDING;
                PENDING: if (clr[i])              state_d[i] = IDLE;
                default:                          state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        req           = '0;
        pending_count = '0;
        for (int i = 0; i < N; i++) begin
            req[i]        = (state_q[i] == PENDING);
            pending_count = pending_count + {2'b00, req[i]};
        end
    end

    assign any_pending             = (pending_count != 3'd0);
    assign floor_1_up_button       = req[0];
    assign floor_2_up_button       = req[1];
    assign floor_2_down_button     = req[2];
    assign floor_3_down_button     = req[3];
    assign elevator_floor_1_button = req[4];
    assign elevator_floor_2_button = req[5];
    assign elevator_floor_3_button = req[6];

endmodule

// File: tb/tb_elevator_call_latch.sv
// Scoreboard bench for elevator_call_latch; honours ELEVATOR_CALL_DEBOUNCE_EN when
// the same macro is given to the build.
module tb_elevator_call_latch;

    localparam int DEB = 4;
`ifdef ELEVATOR_CALL_DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        string      name;
        logic [6:0] req;
        logic [2:0] cnt;
        logic       any;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [6:0] raw = '0;
    logic [6:0] clr = '0;
    logic [6:0] req;
    logic [2:0] pending_count;
    logic       any_pending;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    elevator_call_latch #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk                           (clk),
        .rstn                          (rstn),
        .raw_floor_1_up                (raw[0]),
        .raw_floor_2_up                (raw[1]),
        .raw_floor_2_down              (raw[2]),
        .raw_floor_3_down              (raw[3]),
        .raw_car_floor_1               (raw[4]),
        .raw_car_floor_2               (raw[5]),
        .raw_car_floor_3               (raw[6]),
        .floor_1_up_button_clear       (clr[0]),
        .floor_2_up_button_clear       (clr[1]),
        .floor_2_down_button_clear     (clr[2]),
        .floor_3_down_button_clear     (clr[3]),
        .elevator_floor_1_button_clear (clr[4]),
        .elevator_floor_2_button_clear (clr[5]),
        .elevator_floor_3_button_clear (clr[6]),
        .floor_1_up_button             (req[0]),
        .floor_2_up_button             (req[1]),
        .floor_2_down_button           (req[2]),
        .floor_3_down_button           (req[3]),
        .elevator_floor_1_button       (req[4]),
        .elevator_floor_2_button       (req[5]),
        .elevator_floor_3_button       (req[6]),
        .pending_count                 (pending_count),
        .any_pending                   (any_pending)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected count and any_pending are hand-entered alongside each vector.
    task automatic expect_now(input string name, input logic [6:0] r, input logic [2:0] c,
                              input logic a);
        exp_t e;
        e.name = name;
        e.req  = r;
        e.cnt  = c;
        e.any  = a;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            wait (q.size() != 0);
            e = q.pop_front();
            n_vec++;
            if (req !== e.req || pending_count !== e.cnt || any_pending !== e.any) begin
                n_bad++;
                $display("FAIL %s: got req=%b cnt=%0d any=%b, want req=%b cnt=%0d any=%b",
                         e.name, req, pending_count, any_pending, e.req, e.cnt, e.any);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #3;
        expect_now("reset_state", 7'h00, 3'd0, 1'b0);
        tick(2);
        rstn = 1'b1;
        tick(2);

        // Held car-2 button: one request at LAT edges, held until cleared.
        raw[5] = 1'b1;
        tick(LAT - 1);
        expect_now("car2_before_latency", 7'h00, 3'd0, 1'b0);
        tick(1);
        expect_now("car2_at_latency", 7'h20, 3'd1, 1'b1);
        tick(15);
        expect_now("car2_held_single", 7'h20, 3'd1, 1'b1);
        raw[5] = 1'b0;
        tick(LAT + 2);
        clr[5] = 1'b1;
        tick(1);
        expect_now("car2_cleared", 7'h00, 3'd0, 1'b0);
        clr[5] = 1'b0;
        tick(2);

        // Two-cycle pulse: rejected with debounce, a valid press without.
        raw[0] = 1'b1;
        tick(2);
        raw[0] = 1'b0;
        tick(LAT + 6);
`ifdef ELEVATOR_CALL_DEBOUNCE_EN
        expect_now("short_pulse_rejected", 7'h00, 3'd0, 1'b0);
`else
        expect_now("short_pulse_latched", 7'h01, 3'd1, 1'b1);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        expect_now("short_pulse_cleared", 7'h00, 3'd0, 1'b0);
`endif
        tick(2);

        // Ten-cycle press on floor_1_up, then floor_3_down on top of it.
        raw[0] = 1'b1;
        tick(LAT - 1);
        expect_now("f1up_before_latency", 7'h00, 3'd0, 1'b0);
        tick(1);
        expect_now("f1up_at_latency", 7'h01, 3'd1, 1'b1);
        tick(10 - LAT);
        raw[0] = 1'b0;
        raw[3] = 1'b1;
        tick(LAT);
        expect_now("two_pending", 7'h09, 3'd2, 1'b1);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        expect_now("f1up_cleared", 7'h08, 3'd1, 1'b1);
        clr[3] = 1'b1;
        tick(1);
        clr[3] = 1'b0;
        expect_now("f3dn_cleared_last", 7'h00, 3'd0, 1'b0);
        raw[3] = 1'b0;
        tick(LAT + 2);

        // Press edge inside a long clear window is absorbed.
        clr[2] = 1'b1;
        raw[2] = 1'b1;
        tick(LAT + 2);
        clr[2] = 1'b0;
        tick(3);
        expect_now("press_absorbed_by_clear", 7'h00, 3'd0, 1'b0);
        raw[2] = 1'b0;
        tick(LAT + 2);
        raw[2] = 1'b1;
        tick(LAT - 1);
        expect_now("repress_before_latency", 7'h00, 3'd0, 1'b0);
        tick(1);
        expect_now("repress_at_latency", 7'h04, 3'd1, 1'b1);
        clr[2] = 1'b1;
        tick(1);
        clr[2] = 1'b0;
        raw[2] = 1'b0;
        tick(LAT + 2);

        // All seven together, then clear channels 1, 3 and 5.
        raw = 7'h7F;
        tick(LAT - 1);
        expect_now("all_before_latency", 7'h00, 3'd0, 1'b0);
        tick(1);
        expect_now("all_seven_latched", 7'h7F, 3'd7, 1'b1);
        clr = 7'h15;
        tick(1);
        clr = 7'h00;
        expect_now("three_cleared", 7'h6A, 3'd4, 1'b1);
        raw = 7'h40;
        tick(3);
        expect_now("four_pending_pre_reset", 7'h6A, 3'd4, 1'b1);

        // Mid-cycle async reset with car-3 still held.
        #3;
        rstn = 1'b0;
        #1;
        expect_now("async_reset_clears", 7'h00, 3'd0, 1'b0);
        tick(2);
        rstn = 1'b1;
        tick(LAT - 1);
        expect_now("held_through_reset_early", 7'h00, 3'd0, 1'b0);
        tick(1);
        expect_now("held_through_reset_latch", 7'h40, 3'd1, 1'b1);
        tick(10);
        expect_now("held_through_reset_single", 7'h40, 3'd1, 1'b1);

        for (int i = 0; i < 100 && q.size() != 0; i++) #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
